// File: rtl/cp_corr_ctrl_pkg.sv
// rtl/cp_corr_ctrl_pkg.sv - shared types and constants for the CP correlator sequencer
// Contents:
//   ctrl_state_t  sequencer states IDLE/FILL/WARM/RUN/DONE
//   N_FFT, L_CP, NUM_SYM_DEF, TIMEOUT_DEF  default geometry
//   cnt_w()       width of a counter holding 0..mod-1 (never below 1 bit)
package cp_corr_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FILL = 3'd1,
    WARM = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } ctrl_state_t;

  localparam int N_FFT       = 256;
  localparam int L_CP        = 16;
  localparam int NUM_SYM_DEF = 20;
  localparam int TIMEOUT_DEF = 1024;

  function automatic int cnt_w(input int mod);
    return (mod > 1) ? $clog2(mod) : 1;
  endfunction

endpackage

// File: rtl/cp_corr_ctrl_if.sv
// rtl/cp_corr_ctrl_if.sv - control/strobe bundle between the sequencer and its user
// Signals:
//   start, abort, in_valid                  driven by master
//   dly_en, busy, fill_done                 driven by slave (sequencer)
//   acc_add, acc_sub, win_valid, sym_end    registered strobes, driven by slave
//   theta_idx, sym_idx, done, timeout       registered status, driven by slave
// Modports: master (user/bench side), slave (sequencer side).
interface cp_corr_ctrl_if #(
  parameter int N       = cp_corr_ctrl_pkg::N_FFT,
  parameter int L       = cp_corr_ctrl_pkg::L_CP,
  parameter int NUM_SYM = cp_corr_ctrl_pkg::NUM_SYM_DEF
);

  localparam int TW = cp_corr_ctrl_pkg::cnt_w(N + L);
  localparam int SW = cp_corr_ctrl_pkg::cnt_w(NUM_SYM + 1);

  logic          start;
  logic          abort;
  logic          in_valid;
  logic          dly_en;
  logic          busy;
  logic          fill_done;
  logic          acc_add;
  logic          acc_sub;
  logic          win_valid;
  logic [TW-1:0] theta_idx;
  logic [SW-1:0] sym_idx;
  logic          sym_end;
  logic          done;
  logic          timeout;

  modport master (
    output start, abort, in_valid,
    input  dly_en, busy, fill_done, acc_add, acc_sub, win_valid,
    input  theta_idx, sym_idx, sym_end, done, timeout
  );

  modport slave (
    input  start, abort, in_valid,
    output dly_en, busy, fill_done, acc_add, acc_sub, win_valid,
    output theta_idx, sym_idx, sym_end, done, timeout
  );

endinterface

// File: rtl/cp_corr_ctrl_wrap_cnt.sv
// rtl/cp_corr_ctrl_wrap_cnt.sv - modulo counter with enable, clear and wrap pulse
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   clr       synchronous clear to 0 (wins over en)
//   en        count one step
//   cnt       current count 0..MOD-1
//   wrap      combinational: en is high and cnt is at MOD-1 (returns to 0 on this edge)
module wrap_cnt #(
  parameter int MOD = 4,
  parameter int W   = (MOD > 1) ? $clog2(MOD) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  assign wrap = en && (cnt == W'(MOD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/cp_corr_ctrl.sv
// rtl/cp_corr_ctrl.sv - sequencer for the N-sample delay line and CP moving-sum correlator
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-high reset
//   ctl   cp_corr_ctrl_if.slave: start/abort/in_valid in; dly_en, busy, fill_done,
//         acc_add/acc_sub/win_valid, theta_idx, sym_idx, sym_end, done, timeout out
// Optional feature: CTRL_TIMEOUT_EN enables the idle watchdog (TIMEOUT cycles);
// without it timeout is tied to 0.
module cp_corr_ctrl
  import cp_corr_ctrl_pkg::*;
#(
  parameter int N       = N_FFT,
  parameter int L       = L_CP,
  parameter int NUM_SYM = NUM_SYM_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         rst,
  cp_corr_ctrl_if.slave ctl
);

  localparam int TW = cnt_w(N + L);
  localparam int SW = cnt_w(NUM_SYM + 1);
  localparam int CW = cnt_w(N);

  ctrl_state_t   state;
  logic          fill_done_q;
  logic          acc_add_q;
  logic          acc_sub_q;
  logic          win_valid_q;
  logic          sym_end_q;
  logic          done_q;
  logic          timeout_q;
  logic [TW-1:0] theta_q;

  logic          busy;
  logic          active;
  logic          accept;
  logic          go;
  logic          wd_fire;
  logic          kill;
  logic          cnt_clr;
  logic          samp_en;
  logic          theta_en;
  logic          sym_en;
  logic          last_sym;

  logic [CW-1:0] samp_cnt;
  logic          samp_wrap;
  logic [TW-1:0] theta_cnt;
  logic          theta_wrap;
  logic [SW-1:0] sym_cnt;
  logic          sym_wrap;

  // The count values themselves only matter through the wrap pulses for samp_cnt,
  // and sym_cnt never reaches its modulus (DONE is taken at NUM_SYM).
  logic          unused_cnt;
  assign unused_cnt = ^{samp_cnt, sym_wrap};

  assign busy     = (state != IDLE);
  assign active   = (state == FILL) || (state == WARM) || (state == RUN);
  assign accept   = ctl.in_valid && active;
  assign go       = (state == IDLE) && ctl.start && !ctl.abort;
  assign kill     = ctl.abort || wd_fire;
  assign cnt_clr  = kill || go;
  assign samp_en  = accept && (state == FILL);
  assign theta_en = accept && ((state == WARM) || (state == RUN));
  // theta_wrap already includes theta_en, so this is one pulse per completed symbol.
  assign sym_en   = theta_wrap && (state == RUN);
  assign last_sym = sym_en && (sym_cnt == SW'(NUM_SYM - 1));

  wrap_cnt #(.MOD(N), .W(CW)) u_samp_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (samp_en),
    .cnt  (samp_cnt),
    .wrap (samp_wrap)
  );

  wrap_cnt #(.MOD(N + L), .W(TW)) u_theta_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (theta_en),
    .cnt  (theta_cnt),
    .wrap (theta_wrap)
  );

  wrap_cnt #(.MOD(NUM_SYM + 1), .W(SW)) u_sym_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (sym_en),
    .cnt  (sym_cnt),
    .wrap (sym_wrap)
  );

`ifdef CTRL_TIMEOUT_EN
  localparam int WW = cnt_w(TIMEOUT + 1);
  logic [WW-1:0] wd_cnt;

  // Counts consecutive busy cycles without a sample; any sample restarts it.
  assign wd_fire = busy && !ctl.in_valid && (wd_cnt == WW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (!busy || ctl.in_valid || wd_fire || ctl.abort) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + WW'(1);
    end
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign wd_fire        = 1'b0;
`endif

  // Strobes are registered so they line up with the delay line's one-cycle output latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      fill_done_q <= 1'b0;
      acc_add_q   <= 1'b0;
      acc_sub_q   <= 1'b0;
      win_valid_q <= 1'b0;
      sym_end_q   <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      theta_q     <= '0;
    end else begin
      acc_add_q   <= 1'b0;
      acc_sub_q   <= 1'b0;
      win_valid_q <= 1'b0;
      sym_end_q   <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      if (kill) begin
        // abort also overrides a same-cycle start or final sample
        state       <= IDLE;
        fill_done_q <= 1'b0;
        theta_q     <= '0;
        timeout_q   <= wd_fire;
      end else begin
        unique case (state)
          IDLE: begin
            if (ctl.start) begin
              state   <= FILL;
              theta_q <= '0;
            end
          end
          FILL: begin
            if (samp_wrap) begin
              state       <= WARM;
              fill_done_q <= 1'b1;
            end
          end
          WARM: begin
            if (accept) begin
              acc_add_q <= 1'b1;
              theta_q   <= theta_cnt;
              if (theta_cnt == TW'(L - 1)) begin
                state <= RUN;
              end
            end
          end
          RUN: begin
            if (accept) begin
              acc_add_q   <= 1'b1;
              acc_sub_q   <= 1'b1;
              win_valid_q <= 1'b1;
              theta_q     <= theta_cnt;
              sym_end_q   <= theta_wrap;
              if (last_sym) begin
                state  <= DONE;
                done_q <= 1'b1;
              end
            end
          end
          DONE: begin
            state       <= IDLE;
            fill_done_q <= 1'b0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign ctl.dly_en    = accept;
  assign ctl.busy      = busy;
  assign ctl.fill_done = fill_done_q;
  assign ctl.acc_add   = acc_add_q;
  assign ctl.acc_sub   = acc_sub_q;
  assign ctl.win_valid = win_valid_q;
  assign ctl.theta_idx = theta_q;
  assign ctl.sym_idx   = sym_cnt;
  assign ctl.sym_end   = sym_end_q;
  assign ctl.done      = done_q;
  assign ctl.timeout   = timeout_q;

endmodule
